fact_param: RTL and testbench



---
 rtl/fact_param.sv | 131 +++++++++++++
 tb/tb_fact_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_param.sv
// fact_param -- iterative factorial engine, one multiply per clock.
//
// Computes nf = n! for an IN_W-bit operand into an OUT_W-bit result.
// A product that no longer fits in OUT_W bits raises err instead of
// wrapping. An operand above MAX_N also raises err, without any
// computation taking place.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      asynchronous reset, active low
//   go    in   1      start request, accepted only when not busy
//   n     in   IN_W   operand, captured on the edge that accepts go
//   busy  out  1      computation in progress
//   done  out  1      sticky success flag, nf valid while set
//   err   out  1      sticky failure flag (range or overflow)
//   nf    out  OUT_W  result
module fact_param #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int MAX_N = 2**IN_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [IN_W-1:0]  n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [OUT_W-1:0] nf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam longint unsigned N_ALL = (64'd1 << IN_W) - 64'd1;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0]   prod_q, prod_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [OUT_W-1:0]   nf_q, nf_d;
  logic [OUT_W+IN_W-1:0] p;
  logic               range_err;

  // When MAX_N covers every encodable operand the range check is
  // structurally absent; otherwise compare at operand width.
  generate
    if (longint'(MAX_N) >= longint'(N_ALL)) begin : g_no_range
      assign range_err = 1'b0;
    end else begin : g_range
      assign range_err = (n > IN_W'(MAX_N));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      nf_q    <= nf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    nf_d    = nf_q;
    // Full-width product so any bit spilling past OUT_W is visible.
    p = {{IN_W{1'b0}}, prod_q} * {{OUT_W{1'b0}}, cnt_q};

    case (state_q)
      S_RUN: begin
        if (cnt_q <= IN_W'(1)) begin
          nf_d    = prod_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (p[OUT_W+IN_W-1:OUT_W] != '0) begin
          err_d   = 1'b1;
          nf_d    = '0;
          busy_d  = 1'b0;
          state_d = S_ERR;
        end else begin
          prod_d = p[OUT_W-1:0];
          cnt_d  = cnt_q - IN_W'(1);
        end
      end
      default: begin
        // IDLE, DONE and ERR all accept a new request; go held high in
        // DONE therefore chains straight into the next computation.
        if (go) begin
          if (range_err) begin
            err_d   = 1'b1;
            done_d  = 1'b0;
            nf_d    = '0;
            state_d = S_ERR;
          end else begin
            cnt_d   = n;
            prod_d  = OUT_W'(1);
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign nf   = nf_q;

endmodule

// File: tb/tb_fact_param.sv
module tb_fact_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [3:0]  n = '0;
  logic        busy, done, err;
  logic [15:0] nf;

  logic        go2 = 1'b0;
  logic [3:0]  n2 = '0;
  logic        busy2, done2, err2;
  logic [15:0] nf2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fact_param #(.IN_W(4), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy), .done(done), .err(err), .nf(nf)
  );

  fact_param #(.IN_W(4), .OUT_W(16), .MAX_N(7)) dut7 (
    .clk(clk), .rst(rst), .go(go2), .n(n2),
    .busy(busy2), .done(done2), .err(err2), .nf(nf2)
  );

  // Reference: multiply n*(n-1)*...*2 as plain integers; the first
  // partial product reaching 2**16 is the overflow, one cycle per multiply.
  function automatic void model(input int nv, output longint val,
                                output bit e, output int lat);
    longint pr = 1;
    e = 0;
    lat = (nv < 1) ? 1 : nv;
    for (int c = nv; c >= 2; c--) begin
      pr = pr * c;
      if (pr >= 65536) begin
        e = 1;
        lat = nv - c + 1;
        val = 0;
        return;
      end
    end
    val = pr;
  endfunction

  // One-cycle go pulse on the main instance.
  task automatic start(input logic [3:0] v);
    @(negedge clk);
    go = 1'b1;
    n  = v;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Count edges until done or err shows; note protocol violations seen.
  task automatic wait_finish(output int cycles, output bit busy_bad,
                             output bit both_bad);
    cycles = 0;
    busy_bad = 0;
    both_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 cycles++;
      if (done && err) both_bad = 1;
      if (done || err) begin
        if (busy) busy_bad = 1;
        return;
      end
      if (busy !== 1'b1) busy_bad = 1;
    end
    cycles = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, nf} !== 19'd0 || {busy2, done2, err2, nf2} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b nf=%0d, required all 0", busy, done, err, nf);
    end
    rst = 1'b1;
  endtask

  task automatic test_n5;
    int cyc; bit bb, db;
    start(4'd5);
    wait_finish(cyc, bb, db);
    n_checks++;
    if (cyc !== 5 || bb || db) begin
      n_fail++;
      $display("FAIL n5_latency: got %0d cycles busy_bad=%b both=%b, required 5", cyc, bb, db);
    end
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || nf !== 16'd120) begin
      n_fail++;
      $display("FAIL n5_result: got done=%b err=%b nf=%0d, required done=1 err=0 nf=120", done, err, nf);
    end
    repeat (3) @(posedge clk);
    #1 n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || nf !== 16'd120) begin
      n_fail++;
      $display("FAIL n5_hold: got done=%b err=%b busy=%b nf=%0d, required 1/0/0/120", done, err, busy, nf);
    end
  endtask

  task automatic test_small;
    int cyc; bit bb, db;
    for (int v = 0; v <= 1; v++) begin
      start(4'(v));
      wait_finish(cyc, bb, db);
      n_checks++;
      if (cyc !== 1 || done !== 1'b1 || nf !== 16'd1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL small_n%0d: got cycles=%0d done=%b nf=%0d err=%b, required 1/1/1/0", v, cyc, done, nf, err);
      end
    end
  endtask

  task automatic test_n8_n9;
    int cyc; bit bb, db;
    start(4'd8);
    wait_finish(cyc, bb, db);
    n_checks++;
    if (cyc !== 8 || done !== 1'b1 || nf !== 16'h9D80 || bb || db) begin
      n_fail++;
      $display("FAIL n8: got cycles=%0d done=%b nf=%0d, required 8/1/40320", cyc, done, nf);
    end
    start(4'd9);
    wait_finish(cyc, bb, db);
    n_checks++;
    if (cyc !== 7 || err !== 1'b1 || done !== 1'b0 || nf !== 16'd0 || bb || db) begin
      n_fail++;
      $display("FAIL n9_overflow: got cycles=%0d err=%b done=%b nf=%0d, required 7/1/0/0", cyc, err, done, nf);
    end
  endtask

  task automatic test_range;
    bit saw_busy = 0;
    @(negedge clk);
    go2 = 1'b1;
    n2  = 4'd8;
    @(posedge clk);
    #1 go2 = 1'b0;
    n_checks++;
    if (err2 !== 1'b1 || done2 !== 1'b0 || busy2 !== 1'b0 || nf2 !== 16'd0) begin
      n_fail++;
      $display("FAIL range_err: got err=%b done=%b busy=%b nf=%0d, required 1/0/0/0", err2, done2, busy2, nf2);
    end
    repeat (4) begin
      @(negedge clk);
      if (busy2) saw_busy = 1;
    end
    n_checks++;
    if (saw_busy || err2 !== 1'b1) begin
      n_fail++;
      $display("FAIL range_hold: got busy_seen=%b err=%b, required 0/1", saw_busy, err2);
    end
    // In-range operand on the restricted instance still computes.
    @(negedge clk);
    go2 = 1'b1;
    n2  = 4'd7;
    @(posedge clk);
    #1 go2 = 1'b0;
    repeat (7) @(posedge clk);
    #1 n_checks++;
    if (done2 !== 1'b1 || err2 !== 1'b0 || nf2 !== 16'd5040) begin
      n_fail++;
      $display("FAIL range_n7: got done=%b err=%b nf=%0d, required 1/0/5040", done2, err2, nf2);
    end
  endtask

  task automatic test_ignore_go;
    int cyc; bit bb, db;
    start(4'd6);
    @(negedge clk);
    go = 1'b1;
    n  = 4'd3;
    @(posedge clk);
    #1 go = 1'b0;
    n = 4'd2;
    wait_finish(cyc, bb, db);
    n_checks++;
    if (cyc + 1 !== 6 || nf !== 16'd720 || done !== 1'b1 || bb) begin
      n_fail++;
      $display("FAIL ignore_go: got cycles=%0d nf=%0d done=%b, required 6/720/1", cyc + 1, nf, done);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit bb, db;
    // Currently in DONE; hold go high across the accepting edge.
    @(negedge clk);
    go = 1'b1;
    n  = 4'd3;
    @(posedge clk);
    #1 n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_handover: got done=%b busy=%b, required 0/1", done, busy);
    end
    go = 1'b0;
    wait_finish(cyc, bb, db);
    n_checks++;
    if (cyc !== 3 || nf !== 16'd6 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result: got cycles=%0d nf=%0d done=%b, required 3/6/1", cyc, nf, done);
    end
  endtask

  task automatic test_async_reset;
    int cyc; bit bb, db;
    start(4'd6);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 n_checks++;
    if ({busy, done, err, nf} !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b err=%b nf=%0d, required all 0", busy, done, err, nf);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, nf} !== 19'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b done=%b err=%b nf=%0d, required all 0", busy, done, err, nf);
    end
    start(4'd4);
    wait_finish(cyc, bb, db);
    n_checks++;
    if (cyc !== 4 || nf !== 16'd24 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_recover: got cycles=%0d nf=%0d done=%b, required 4/24/1", cyc, nf, done);
    end
  endtask

  task automatic test_random;
    int cyc; bit bb, db;
    longint ev; bit ee; int el;
    for (int i = 0; i < 16; i++) begin
      int v = $urandom_range(0, 15);
      model(v, ev, ee, el);
      start(4'(v));
      n = 4'($urandom);
      wait_finish(cyc, bb, db);
      n_checks++;
      if (cyc !== el || err !== ee || done !== !ee || nf !== 16'(ev) || bb || db) begin
        n_fail++;
        $display("FAIL random_n%0d: got cycles=%0d err=%b done=%b nf=%0d, required %0d/%b/%b/%0d",
                 v, cyc, err, done, nf, el, ee, !ee, ev);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_n5;
    test_small;
    test_n8_n9;
    test_range;
    test_ignore_go;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
